// File: rtl/fir_pkg.sv
// fir_pkg: shared types and constants for the time-multiplexed FIR sequencer.
//   fir_state_t : controller states
//   Q15_MAX/MIN : Q1.15 saturation limits
//   RND         : rounding offset applied before the >>15 rescale (half LSB)
//   NTAPS_DEF / ACC_W_DEF : default tap count and accumulator width
package fir_pkg;

  localparam int NTAPS_DEF = 16;
  localparam int ACC_W_DEF = 40;

  localparam logic signed [15:0] Q15_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q15_MIN = 16'sh8000;
  localparam int                 RND     = 2**14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fir_state_t;

endpackage

// File: rtl/q15_round_sat.sv
// q15_round_sat: converts a full-precision Q2.30-scaled accumulator to Q1.15.
// Round-half-up ((acc + 2^14) >>> 15) followed by a clamp to the Q1.15 range.
// Purely combinational; the parent registers the result.
//   i_acc : ACC_W-bit signed accumulator
//   o_q15 : rounded, saturated Q1.15 value
module q15_round_sat
  import fir_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [15:0]      o_q15
);

  localparam logic signed [ACC_W-15:0] SAT_HI = (ACC_W-14)'(Q15_MAX);
  localparam logic signed [ACC_W-15:0] SAT_LO = (ACC_W-14)'(Q15_MIN);

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  logic signed [ACC_W:0]    w_sum;
  logic signed [ACC_W-15:0] w_shf;

  always_comb begin
    w_sum = {i_acc[ACC_W-1], i_acc} + (ACC_W+1)'(RND);
    // Dropping the low 15 bits of a two's-complement value is an arithmetic
    // shift right (floor), which together with +2^14 gives round-half-up.
    w_shf = w_sum[ACC_W:15];
    if (w_shf > SAT_HI) begin
      o_q15 = Q15_MAX;
    end else if (w_shf < SAT_LO) begin
      o_q15 = Q15_MIN;
    end else begin
      o_q15 = w_shf[15:0];
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: NTAPS-tap FIR that time-shares one external signed
// 16x16 MAC. Holds the sample delay line and the coefficient bank, issues one
// tap per cycle, accumulates at full precision and returns a rounded,
// saturated Q1.15 result.
//
// Ports
//   i_clk, i_reset         : clock, synchronous active-high reset
//   i_sample_in/valid, o_sample_ready : Q1.15 sample input handshake
//   o_y_out/o_out_valid, i_out_ready  : Q1.15 result output handshake
//   i_coef_we/addr/wdata, o_coef_ready : coefficient bank write port
//   o_mac_a/b/c            : MAC operands (sample, coefficient, addend = 0)
//   i_mac_result           : MAC product, valid one cycle after its operands
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a sample and coefficient writes; MAC operands zero
// RUN   | one tap per cycle issued to the MAC, tap 0 (newest) first
// DRAIN | accumulates the product of the last tap
// DONE  | first cycle registers y_out, then holds it with out_valid=1
//       | until out_ready
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [15:0]              i_sample_in,
  input  logic                     i_sample_valid,
  output logic                     o_sample_ready,
  output logic [15:0]              o_y_out,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  input  logic                     i_coef_we,
  input  logic [$clog2(NTAPS)-1:0] i_coef_addr,
  input  logic [15:0]              i_coef_wdata,
  output logic                     o_coef_ready,
  output logic [15:0]              o_mac_a,
  output logic [15:0]              o_mac_b,
  output logic [15:0]              o_mac_c,
  input  logic [31:0]              i_mac_result
);

  localparam int AW = $clog2(NTAPS);

  fir_state_t r_state;
  fir_state_t w_state_nxt;

  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_tap;
  logic [AW-1:0]           w_rd_idx;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic                    r_prod_vld;
  logic [15:0]             r_delay [NTAPS];
  logic [15:0]             r_coef  [NTAPS];
  logic [15:0]             r_y_out;
  logic                    r_out_valid;

  logic                    w_accept;
  logic                    w_issue;
  logic                    w_last_tap;
  logic                    w_coef_wr;
  logic signed [15:0]      w_y_rnd;

  q15_round_sat #(
    .ACC_W (ACC_W)
  ) u_round_sat (
    .i_acc (r_acc),
    .o_q15 (w_y_rnd)
  );

  // Next state and handshake outputs.
  always_comb begin
    w_state_nxt    = r_state;
    o_sample_ready = 1'b0;
    o_coef_ready   = 1'b0;
    w_accept       = 1'b0;
    w_issue        = 1'b0;
    w_last_tap     = (r_tap == AW'(NTAPS-1));
    case (r_state)
      IDLE: begin
        o_sample_ready = 1'b1;
        o_coef_ready   = 1'b1;
        if (i_sample_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_issue = 1'b1;
        if (w_last_tap) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        w_state_nxt = DONE;
      end
      DONE: begin
        if (r_out_valid && i_out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_coef_wr  = i_coef_we & o_coef_ready;
  // wr_ptr still points at the newest sample during RUN, so newest-minus-tap
  // walks back through history and wraps naturally in AW bits.
  assign w_rd_idx   = r_wr_ptr - r_tap;
  assign w_prod_ext = {{(ACC_W-32){i_mac_result[31]}}, i_mac_result};

  assign o_mac_a     = w_issue ? r_delay[w_rd_idx] : 16'h0000;
  assign o_mac_b     = w_issue ? r_coef[r_tap]     : 16'h0000;
  assign o_mac_c     = 16'h0000;
  assign o_y_out     = r_y_out;
  assign o_out_valid = r_out_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_tap       <= '0;
      r_acc       <= '0;
      r_prod_vld  <= 1'b0;
      r_y_out     <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        r_delay[i] <= '0;
        r_coef[i]  <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      // The MAC result lags its operands by one cycle.
      r_prod_vld <= w_issue;

      if (w_accept) begin
        r_delay[r_wr_ptr] <= i_sample_in;
        r_acc             <= '0;
        r_tap             <= '0;
      end else if (r_prod_vld) begin
        r_acc <= r_acc + w_prod_ext;
      end

      if (w_issue) begin
        r_tap <= r_tap + AW'(1);
        if (w_last_tap) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
      end

      // Written on the accept edge too, so tap 0 of that run already sees it.
      if (w_coef_wr) begin
        r_coef[i_coef_addr] <= i_coef_wdata;
      end

      if (r_state == DONE) begin
        if (!r_out_valid) begin
          r_y_out     <= w_y_rnd;
          r_out_valid <= 1'b1;
        end else if (i_out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

endmodule
